// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: state encodings, port ids and default widths shared by
// the PSRAM arbiter, the access sequencer and the CPU memory stage.
package ram_arbiter_pkg;

  localparam int ADDR_W_DFLT = 26;
  localparam int DATA_W_DFLT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational grant select between data and fetch ports.
// RAM_ARB_RR_EN selects round-robin; otherwise the data port wins contention.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  logic contend_id;

`ifdef RAM_ARB_RR_EN
  assign contend_id = ~last_grant;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign contend_id = PORT_D;
`endif

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = PORT_D;
    unique case (1'b1)
      req0 && req1:  gnt_id = contend_id;
      !req0 && req1: gnt_id = PORT_I;
      default:       gnt_id = PORT_D;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the PSRAM access sequencer between the data memory
// stage (port 0) and instruction fetch (port 1). Build option: RAM_ARB_RR_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DFLT,
  parameter int DATA_W        = DATA_W_DFLT,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ctl_mem,
  output logic              ctl_rw,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  input  logic [DATA_W-1:0] ctl_rdata
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cycles
    $error("ram_arbiter: ACCESS_CYCLES must be within 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic pick_valid;
  logic pick_id;

  ram_arb_pick u_pick (
    .req0       (p0_req),
    .req1       (p1_req),
    .last_grant (last_q),
    .gnt_valid  (pick_valid),
    .gnt_id     (pick_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= PORT_D;
      last_q  <= PORT_I;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ISSUE;
          gnt_d   = pick_id;
          last_d  = pick_id;
          rw_d    = pick_id ? ~p1_we : ~p0_we;
          addr_d  = pick_id ? p1_addr : p0_addr;
          wdata_d = pick_id ? p1_wdata : p0_wdata;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Writes leave the last read value visible.
          if (rw_q) rdata_d = ctl_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctl_mem = (state_q == ST_ISSUE);
    p0_ack  = (state_q == ST_DONE) && (gnt_q == PORT_D);
    p1_ack  = (state_q == ST_DONE) && (gnt_q == PORT_I);
  end

  assign ctl_rw    = rw_q;
  assign ctl_addr  = addr_q;
  assign ctl_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of the PSRAM arbiter
// against a transaction-level model of grants, latency and memory contents.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int AW = 26;
  localparam int DW = 16;
  localparam int AC = 3;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_ack, p1_ack, ctl_mem, ctl_rw;
  logic [DW-1:0] rdata, ctl_wdata;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_rdata = '0;

  logic          s1_req = 1'b0, s15_req = 1'b0, s_zero = 1'b0;
  logic [AW-1:0] s_addr = 26'h55;
  logic [DW-1:0] s_data = 16'h1234, s_rd = 16'h0;
  logic          s1_a0, s1_a1, s1_mem, s1_rw;
  logic          s15_a0, s15_a1, s15_mem, s15_rw;
  logic [AW-1:0] s1_caddr, s15_caddr;
  logic [DW-1:0] s1_cwd, s1_rdata, s15_cwd, s15_rdata;

  int pass_n = 0;
  int total_n = 0;
  int strobes = 0;
  bit lg = 1'b1;
  logic          last_rw;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic [DW-1:0] seq_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack),
    .rdata(rdata), .ctl_mem(ctl_mem), .ctl_rw(ctl_rw),
    .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_rdata(ctl_rdata)
  );

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1)) u_s1 (
    .clk(clk), .rst(rst),
    .p0_req(s1_req), .p0_we(s_zero), .p0_addr(s_addr),
    .p0_wdata(s_data), .p0_ack(s1_a0),
    .p1_req(s_zero), .p1_we(s_zero), .p1_addr(s_addr),
    .p1_wdata(s_data), .p1_ack(s1_a1),
    .rdata(s1_rdata), .ctl_mem(s1_mem), .ctl_rw(s1_rw),
    .ctl_addr(s1_caddr), .ctl_wdata(s1_cwd), .ctl_rdata(s_rd)
  );

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(15)) u_s15 (
    .clk(clk), .rst(rst),
    .p0_req(s15_req), .p0_we(s_zero), .p0_addr(s_addr),
    .p0_wdata(s_data), .p0_ack(s15_a0),
    .p1_req(s_zero), .p1_we(s_zero), .p1_addr(s_addr),
    .p1_wdata(s_data), .p1_ack(s15_a1),
    .rdata(s15_rdata), .ctl_mem(s15_mem), .ctl_rw(s15_rw),
    .ctl_addr(s15_caddr), .ctl_wdata(s15_cwd), .ctl_rdata(s_rd)
  );

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  // Sequencer stand-in: one memory operation per strobe.
  always @(posedge clk) begin
    if (ctl_mem) begin
      strobes++;
      last_rw = ctl_rw;
      last_addr = ctl_addr;
      last_wdata = ctl_wdata;
      if (!ctl_rw) seq_mem[ctl_addr] = ctl_wdata;
      else ctl_rdata = seq_mem.exists(ctl_addr) ? seq_mem[ctl_addr] : dflt(ctl_addr);
    end
  end

  function automatic bit exp_pick(input bit r0, input bit r1, input bit l);
    if (r0 && r1) return RR ? ~l : 1'b0;
    return r1;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input int budget, output int n, output logic [1:0] v);
    n = 0;
    v = 2'b00;
    while (n < budget) begin
      step();
      n++;
      v = {p1_ack, p0_ack};
      if (v != 2'b00) break;
    end
  endtask

  task automatic test_reset();
    logic [2*DW+AW+3:0] got, exp;
    rst = 1'b1; p0_req = 1'b1; p0_we = 1'b0; p0_addr = 26'h10;
    step(3);
    exp = {1'b0, 1'b0, 1'b0, 1'b1, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}};
    got = {p0_ack, p1_ack, ctl_mem, ctl_rw, ctl_addr, ctl_wdata, rdata};
    total_n++;
    if (got !== exp) $display("FAIL reset_main: got %h want %h", got, exp); else pass_n++;
    got = {s1_a0, s1_a1, s1_mem, s1_rw, s1_caddr, s1_cwd, s1_rdata};
    total_n++;
    if (got !== exp) $display("FAIL reset_s1: got %h want %h", got, exp); else pass_n++;
    got = {s15_a0, s15_a1, s15_mem, s15_rw, s15_caddr, s15_cwd, s15_rdata};
    total_n++;
    if (got !== exp) $display("FAIL reset_s15: got %h want %h", got, exp); else pass_n++;
    rst = 1'b0;
    lg = 1'b1;
    lg = exp_pick(1'b1, 1'b0, lg);
    step();
    total_n++;
    if ({ctl_mem, ctl_addr} !== {1'b1, 26'h10})
      $display("FAIL reset_first_strobe: got %b/%h want 1/10", ctl_mem, ctl_addr);
    else pass_n++;
    step(1 + AC);
    total_n++;
    if ({p1_ack, p0_ack} !== 2'b01)
      $display("FAIL reset_ack: got %b want 01", {p1_ack, p0_ack});
    else pass_n++;
    p0_req = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    seq_mem[26'h123] = 16'hBEEF;
    ref_mem[26'h123] = 16'hBEEF;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 26'h123; p1_wdata = 16'h0;
    lg = exp_pick(1'b0, 1'b1, lg);
    step();
    total_n++;
    if ({ctl_mem, ctl_rw, ctl_addr} !== {1'b1, 1'b1, 26'h123})
      $display("FAIL read_strobe: got %b%b/%h want 11/123", ctl_mem, ctl_rw, ctl_addr);
    else pass_n++;
    step();
    total_n++;
    if (ctl_mem !== 1'b0) $display("FAIL read_strobe_once: got %b want 0", ctl_mem);
    else pass_n++;
    step(2);
    total_n++;
    if ({p1_ack, p0_ack} !== 2'b00)
      $display("FAIL read_early_ack: got %b want 00", {p1_ack, p0_ack});
    else pass_n++;
    step();
    total_n++;
    if ({p1_ack, p0_ack} !== 2'b10)
      $display("FAIL read_ack: got %b want 10", {p1_ack, p0_ack});
    else pass_n++;
    total_n++;
    if (rdata !== 16'hBEEF) $display("FAIL read_data: got %h want beef", rdata);
    else pass_n++;
    p1_req = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    logic [AW+DW:0] exp;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 26'h3FFFFFF; p0_wdata = 16'hA55A;
    lg = exp_pick(1'b1, 1'b0, lg);
    exp = {1'b0, 26'h3FFFFFF, 16'hA55A};
    for (int c = 1; c <= 2 + AC; c++) begin
      step();
      total_n++;
      if ({ctl_rw, ctl_addr, ctl_wdata} !== exp)
        $display("FAIL write_ctl c%0d: got %h want %h", c, {ctl_rw, ctl_addr, ctl_wdata}, exp);
      else pass_n++;
    end
    total_n++;
    if ({p1_ack, p0_ack} !== 2'b01)
      $display("FAIL write_ack: got %b want 01", {p1_ack, p0_ack});
    else pass_n++;
    total_n++;
    if (rdata !== 16'hBEEF) $display("FAIL write_rdata_kept: got %h want beef", rdata);
    else pass_n++;
    ref_mem[26'h3FFFFFF] = 16'hA55A;
    p0_req = 1'b0; p0_we = 1'b0;
    step();
  endtask

  task automatic test_contention();
    int n;
    logic [1:0] v;
    bit w;
    p0_req = 1'b1; p0_addr = 26'h200;
    p1_req = 1'b1; p1_addr = 26'h300;
    for (int k = 0; k < 4; k++) begin
      w = exp_pick(p0_req, p1_req, lg);
      lg = w;
      wait_ack(20, n, v);
      total_n++;
      if (v !== (w ? 2'b10 : 2'b01))
        $display("FAIL contend_port k%0d: got %b want %b", k, v, w ? 2'b10 : 2'b01);
      else pass_n++;
      total_n++;
      if (n !== (k == 0 ? 2 + AC : 3 + AC))
        $display("FAIL contend_gap k%0d: got %0d want %0d", k, n, k == 0 ? 2 + AC : 3 + AC);
      else pass_n++;
      if (w) p1_addr = p1_addr + 26'd1;
      else p0_addr = p0_addr + 26'd1;
    end
    p0_req = 1'b0;
    for (int k = 0; k < 2 && (p0_req || p1_req); k++) begin
      w = exp_pick(p0_req, p1_req, lg);
      lg = w;
      wait_ack(20, n, v);
      total_n++;
      if (v !== (w ? 2'b10 : 2'b01))
        $display("FAIL contend_drain: got %b want %b", v, w ? 2'b10 : 2'b01);
      else pass_n++;
      if (w) p1_req = 1'b0;
      else p0_req = 1'b0;
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n, s0;
    logic [1:0] v;
    s0 = strobes;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 26'h40;
    lg = exp_pick(1'b1, 1'b0, lg);
    wait_ack(20, n, v);
    p0_addr = 26'h41;
    lg = exp_pick(1'b1, 1'b0, lg);
    step(2);
    total_n++;
    if ({ctl_mem, ctl_addr} !== {1'b1, 26'h41})
      $display("FAIL b2b_second_strobe: got %b/%h want 1/41", ctl_mem, ctl_addr);
    else pass_n++;
    wait_ack(20, n, v);
    total_n++;
    if ({v, n} !== {2'b01, 32'(AC + 1)})
      $display("FAIL b2b_second_ack: got %b@%0d want 01@%0d", v, n, AC + 1);
    else pass_n++;
    p0_req = 1'b0;
    step(4);
    total_n++;
    if (strobes - s0 !== 2) $display("FAIL b2b_no_dup: got %0d want 2", strobes - s0);
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    int s0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 26'h77;
    lg = exp_pick(1'b0, 1'b1, lg);
    step(3);
    s0 = strobes;
    rst = 1'b1;
    #1;
    total_n++;
    if ({ctl_mem, p0_ack, p1_ack, ctl_rw, ctl_addr} !== {4'b0001, 26'h0})
      $display("FAIL rstmid_clear: got %b/%h want 0001/0", {ctl_mem, p0_ack, p1_ack, ctl_rw}, ctl_addr);
    else pass_n++;
    step(2);
    total_n++;
    if ({ctl_mem, p0_ack, p1_ack} !== 3'b000)
      $display("FAIL rstmid_hold: got %b want 000", {ctl_mem, p0_ack, p1_ack});
    else pass_n++;
    rst = 1'b0;
    lg = 1'b1;
    lg = exp_pick(1'b0, 1'b1, lg);
    step();
    total_n++;
    if ({ctl_mem, ctl_addr} !== {1'b1, 26'h77})
      $display("FAIL rstmid_reissue: got %b/%h want 1/77", ctl_mem, ctl_addr);
    else pass_n++;
    step(1 + AC);
    total_n++;
    if ({p1_ack, p0_ack} !== 2'b10)
      $display("FAIL rstmid_ack: got %b want 10", {p1_ack, p0_ack});
    else pass_n++;
    total_n++;
    if (rdata !== dflt(26'h77)) $display("FAIL rstmid_rdata: got %h want %h", rdata, dflt(26'h77));
    else pass_n++;
    total_n++;
    if (strobes - s0 !== 1) $display("FAIL rstmid_strobes: got %0d want 1", strobes - s0);
    else pass_n++;
    p1_req = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    int t1, t15;
    t1 = -1; t15 = -1;
    s1_req = 1'b1; s15_req = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (s1_a0 && t1 < 0) begin t1 = n; s1_req = 1'b0; end
      if (s15_a0 && t15 < 0) begin t15 = n; s15_req = 1'b0; end
    end
    total_n++;
    if (t1 !== 3) $display("FAIL sweep_ac1: got %0d want 3", t1); else pass_n++;
    total_n++;
    if (t15 !== 17) $display("FAIL sweep_ac15: got %0d want 17", t15); else pass_n++;
  endtask

  task automatic new_req(input bit p);
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    we = 1'($urandom_range(0, 1));
    a = ($urandom_range(0, 1) != 0 ? 26'h3FFFFF8 : 26'h0) | AW'($urandom_range(0, 7));
    d = DW'($urandom);
    if (p) begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; end
    else begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; end
  endtask

  task automatic test_random();
    int served, n, s0, it, exp_n;
    logic [1:0] v;
    bit w, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, exp_rd;
    served = 0; it = 0;
    exp_n = 2 + AC;
    exp_rd = dflt(26'h77);
    while ((served < 40 || p0_req || p1_req) && it < 100) begin
      it++;
      if (!p0_req && !p1_req) begin
        n = $urandom_range(1, 3);
        if (n[0]) new_req(1'b0);
        if (n[1]) new_req(1'b1);
      end
      w = exp_pick(p0_req, p1_req, lg);
      lg = w;
      e_we = w ? p1_we : p0_we;
      e_addr = w ? p1_addr : p0_addr;
      e_wd = w ? p1_wdata : p0_wdata;
      s0 = strobes;
      wait_ack(12, n, v);
      total_n++;
      if ({v, n} !== {(w ? 2'b10 : 2'b01), 32'(exp_n)})
        $display("FAIL rand_ack %0d: got %b@%0d want %b@%0d", it, v, n, w ? 2'b10 : 2'b01, exp_n);
      else pass_n++;
      total_n++;
      if ({strobes - s0, last_rw, last_addr, last_wdata} !== {32'd1, ~e_we, e_addr, e_wd})
        $display("FAIL rand_strobe %0d: got %0d %b %h %h want 1 %b %h %h", it,
                 strobes - s0, last_rw, last_addr, last_wdata, ~e_we, e_addr, e_wd);
      else pass_n++;
      if (e_we) ref_mem[e_addr] = e_wd;
      else exp_rd = ref_mem.exists(e_addr) ? ref_mem[e_addr] : dflt(e_addr);
      total_n++;
      if (rdata !== exp_rd) $display("FAIL rand_rdata %0d: got %h want %h", it, rdata, exp_rd);
      else pass_n++;
      served++;
      exp_n = 3 + AC;
      if (served < 40 && $urandom_range(0, 1) != 0) new_req(w);
      else if (w) p1_req = 1'b0;
      else p0_req = 1'b0;
      if (served < 40 && $urandom_range(0, 3) == 0) begin
        if (!w && !p1_req) new_req(1'b1);
        if (w && !p0_req) new_req(1'b0);
      end
    end
    step(2);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
